// File: rtl/soc_pkg.sv
// Shared SoC constants: TX queue drain-engine state encoding and handshake guard length.
package soc_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] TXQ_IDLE      = 2'd0;
    localparam logic [1:0] TXQ_SEND      = 2'd1;
    localparam logic [1:0] TXQ_WAIT_BUSY = 2'd2;
    localparam logic [1:0] TXQ_WAIT_IDLE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = TXQ_IDLE,
        ST_SEND      = TXQ_SEND,
        ST_WAIT_BUSY = TXQ_WAIT_BUSY,
        ST_WAIT_IDLE = TXQ_WAIT_IDLE
    } txq_state_e;

    // Cycles to wait for the UART to drop ready before assuming it already went busy.
    localparam int unsigned TXQ_GUARD_LEN = 2;
    localparam int unsigned TXQ_GUARD_W   = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers, registered fill level and one-cycle flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic [LVL_W-1:0] level,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign full_c    = (level == LVL_W'(DEPTH));
    assign empty_c   = (level == '0);
    assign pop       = rd_en && !empty_c && !flush;
    // A pop in the same cycle frees a slot, so a write is still taken when full.
    assign push      = wr_en && (!full_c || pop) && !flush;
    assign rd_data_c = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter: buffers bus writes and drains them one
// sendReq handshake at a time.
module uart_tx_queue
    import soc_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    input  logic             flush,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic [7:0]       tx_data,
    output logic             tx_send,
    input  logic             tx_ready
);

    txq_state_e             state_q;
    txq_state_e             state_d;
    logic [TXQ_GUARD_W-1:0] guard_q;
    logic [TXQ_GUARD_W-1:0] guard_d;
    logic [BYTE_W-1:0]      data_q;
    logic [BYTE_W-1:0]      data_d;
    logic                   send_q;
    logic                   send_d;
    logic                   pop_c;
    logic [BYTE_W-1:0]      head_c;
    logic                   fifo_full_c;
    logic                   fifo_empty_c;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_en     (wr_valid),
        .wr_data   (wr_data),
        .rd_en     (pop_c),
        .rd_data_c (head_c),
        .level     (level),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // Drain engine next-state: pop, pulse sendReq, see the UART go busy, wait for it idle.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        data_d  = data_q;
        send_d  = 1'b0;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c && tx_ready && !flush) begin
                    pop_c   = 1'b1;
                    data_d  = head_c;
                    send_d  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                guard_d = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready || (guard_q == TXQ_GUARD_W'(TXQ_GUARD_LEN - 1))) begin
                    guard_d = '0;
                    state_d = ST_WAIT_IDLE;
                end else begin
                    guard_d = guard_q + TXQ_GUARD_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            guard_q <= '0;
            data_q  <= '0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            data_q  <= data_d;
            send_q  <= send_d;
        end
    end

    // Reset masks a pending pulse in its own cycle so an interrupted handshake never fires.
    assign tx_send  = send_q && !reset;
    assign tx_data  = data_q;
    assign wr_ready = !fifo_full_c;
    assign empty    = (level == '0) && (state_q == ST_IDLE);

endmodule
